// File: rtl/quant_ctrl.sv
// quant_ctrl: automatic gain controller for the ACO quantizer.
// Tracks the per-frame peak magnitude of the sample stream, searches for the
// smallest right-shift that keeps the frame inside signed 8 bits, and writes
// that shift to the quantizer with increase-now / decrease-after-hold policy.
// A CFG write always takes priority and can also seed or override the shift.
module quant_ctrl #(
   parameter int I_BW        = 16,
   parameter int SHIFT_BW    = 8,
   parameter int MAX_SHIFT   = 8,
   parameter int HOLD_FRAMES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   en_i,
   input  logic                   cfg_auto_i,
   input  logic [SHIFT_BW-1:0]    cfg_shift_i,
   input  logic                   cfg_wr_en_i,
   input  logic signed [I_BW-1:0] data_i,
   input  logic                   valid_i,
   input  logic                   last_i,
   output logic [SHIFT_BW-1:0]    shift_o,
   output logic                   wr_en_o,
   output logic [I_BW-2:0]        peak_o,
   output logic                   busy_o,
   output logic                   overrun_o
);

   localparam int CAND_BW = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1);
   localparam int HOLD_BW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

   localparam logic [I_BW-2:0]  FIT_LIMIT = (I_BW-1)'(127);
   localparam logic [CAND_BW-1:0] CAND_MAX = CAND_BW'(MAX_SHIFT);
   localparam logic [CAND_BW-1:0] CAND_ONE = CAND_BW'(1);
   localparam logic [HOLD_BW:0]   HOLD_ONE = (HOLD_BW+1)'(1);
   localparam logic [HOLD_BW:0]   HOLD_LIM = (HOLD_BW+1)'(HOLD_FRAMES);

   typedef enum logic {
      IDLE    = 1'b0,
      COMPUTE = 1'b1
   } state_t;

   state_t               state;
   logic [CAND_BW-1:0]   cand;
   logic [I_BW-2:0]      peak_acc;
   logic [I_BW-2:0]      peak_snap;
   logic [HOLD_BW-1:0]   hold_cnt;

   logic                 accept;
   logic                 frame_end;
   logic [I_BW-2:0]      mag;
   logic [I_BW-2:0]      peak_new;
   logic                 fits;
   logic [SHIFT_BW-1:0]  target;
   logic [HOLD_BW:0]     hold_inc;

   // One's-complement magnitude, running max, candidate fit test and the
   // next hold count; all purely combinational helpers for the registers.
   always_comb begin
      accept    = en_i & valid_i;
      frame_end = accept & last_i;
      mag       = data_i[I_BW-1] ? ~data_i[I_BW-2:0] : data_i[I_BW-2:0];
      peak_new  = (mag > peak_acc) ? mag : peak_acc;
      fits      = ((peak_snap >> cand) <= FIT_LIMIT) || (cand == CAND_MAX);
      target    = SHIFT_BW'(cand);
      hold_inc  = {1'b0, hold_cnt} + HOLD_ONE;
   end

   // Peak tracking runs on every accepted beat regardless of FSM state; a
   // frame that closes while a search is still running flags overrun.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         peak_acc  <= '0;
         peak_o    <= '0;
         overrun_o <= 1'b0;
      end else if (accept) begin
         if (last_i) begin
            peak_acc <= '0;
            peak_o   <= peak_new;
            if (state == COMPUTE) begin
               overrun_o <= 1'b1;
            end
         end else begin
            peak_acc <= peak_new;
         end
      end
   end

   // Shift search FSM plus the write decision; a CFG write on the same edge
   // overrides whatever the auto decision produced.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         cand      <= '0;
         peak_snap <= '0;
         shift_o   <= '0;
         wr_en_o   <= 1'b0;
         busy_o    <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         wr_en_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_end) begin
                  state     <= COMPUTE;
                  cand      <= '0;
                  peak_snap <= peak_new;
                  busy_o    <= 1'b1;
               end
            end
            COMPUTE: begin
               if (fits) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  if (cfg_auto_i) begin
                     if (target > shift_o) begin
                        shift_o  <= target;
                        wr_en_o  <= 1'b1;
                        hold_cnt <= '0;
                     end else if (target < shift_o) begin
                        if (hold_inc >= HOLD_LIM) begin
                           shift_o  <= target;
                           wr_en_o  <= 1'b1;
                           hold_cnt <= '0;
                        end else begin
                           hold_cnt <= hold_inc[HOLD_BW-1:0];
                        end
                     end else begin
                        hold_cnt <= '0;
                     end
                  end else begin
                     hold_cnt <= '0;
                  end
               end else begin
                  cand <= cand + CAND_ONE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
         if (cfg_wr_en_i) begin
            shift_o  <= cfg_shift_i;
            wr_en_o  <= 1'b1;
            hold_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_quant_ctrl.sv
// tb_quant_ctrl: directed self-checking bench for quant_ctrl.
module tb_quant_ctrl;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               cfg_auto;
   logic [7:0]         cfg_shift;
   logic               cfg_wr_en;
   logic signed [15:0] data;
   logic               valid;
   logic               last;
   logic [7:0]         shift;
   logic               wr_en;
   logic [14:0]        peak;
   logic               busy;
   logic               overrun;

   int compared   = 0;
   int mismatched = 0;
   int pulses     = 0;
   int base;
   int n;

   quant_ctrl #(
      .I_BW(16), .SHIFT_BW(8), .MAX_SHIFT(8), .HOLD_FRAMES(4)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .cfg_auto_i(cfg_auto),
      .cfg_shift_i(cfg_shift), .cfg_wr_en_i(cfg_wr_en), .data_i(data),
      .valid_i(valid), .last_i(last), .shift_o(shift), .wr_en_o(wr_en),
      .peak_o(peak), .busy_o(busy), .overrun_o(overrun)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Count write pulses mid-cycle, away from the active edge
   always @(negedge clk) if (wr_en === 1'b1) pulses++;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycles(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic l);
      data  = d;
      valid = 1'b1;
      last  = l;
      stepCycles(1);
      valid = 1'b0;
      last  = 1'b0;
      data  = '0;
   endtask

   task automatic cfgWrite(input logic [7:0] v);
      cfg_shift = v;
      cfg_wr_en = 1'b1;
      stepCycles(1);
      cfg_wr_en = 1'b0;
   endtask

   task automatic waitIdle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         stepCycles(1);
         cycles++;
      end
      if (cycles >= 40) checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; cfg_auto = 1'b1; cfg_shift = '0; cfg_wr_en = 1'b0;
      data = '0; valid = 1'b0; last = 1'b0;
      stepCycles(1);
      checkOutput("rst_shift", shift, 0);
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_peak", peak, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      stepCycles(1);

      // en low: beat ignored entirely
      en = 1'b0;
      applyStimulus(16'd30000, 1'b1);
      stepCycles(1);
      checkOutput("en_low_peak", peak, 0);
      checkOutput("en_low_busy", busy, 0);
      en = 1'b1;

      // Peak +100: target 0, no write
      base = pulses;
      applyStimulus(16'd10, 1'b0);
      applyStimulus(16'd100, 1'b0);
      applyStimulus(-16'sd50, 1'b1);
      checkOutput("p100_peak", peak, 100);
      checkOutput("p100_busy_e0", busy, 1);
      waitIdle(n);
      checkOutput("p100_cycles", n, 1);
      checkOutput("p100_shift", shift, 0);
      stepCycles(1);
      checkOutput("p100_pulses", pulses - base, 0);

      // Peak +1000: target 3 after 4 busy cycles
      base = pulses;
      applyStimulus(16'd5, 1'b0);
      applyStimulus(-16'sd7, 1'b0);
      applyStimulus(16'd1000, 1'b1);
      checkOutput("p1000_peak", peak, 1000);
      waitIdle(n);
      checkOutput("p1000_cycles", n, 4);
      checkOutput("p1000_shift", shift, 3);
      checkOutput("p1000_wr_en", wr_en, 1);
      stepCycles(1);
      checkOutput("p1000_wr_en_off", wr_en, 0);
      checkOutput("p1000_pulses", pulses - base, 1);

      // -32768: magnitude 32767, clamped at target 8
      base = pulses;
      applyStimulus(16'd0, 1'b0);
      applyStimulus(16'h8000, 1'b1);
      checkOutput("neg_peak", peak, 32767);
      waitIdle(n);
      checkOutput("neg_cycles", n, 9);
      checkOutput("neg_shift", shift, 8);
      checkOutput("neg_wr_en", wr_en, 1);

      // Decrease hold: four peak-50 frames from shift 3
      cfgWrite(8'd3);
      checkOutput("seed3_shift", shift, 3);
      checkOutput("seed3_wr_en", wr_en, 1);
      stepCycles(1);
      base = pulses;
      for (int f = 1; f <= 4; f++) begin
         applyStimulus(16'd20, 1'b0);
         applyStimulus(16'd50, 1'b1);
         waitIdle(n);
         if (f < 4) begin
            checkOutput("hold_shift_kept", shift, 3);
         end else begin
            checkOutput("hold_shift_dropped", shift, 0);
            checkOutput("hold_wr_en", wr_en, 1);
         end
      end
      stepCycles(1);
      checkOutput("hold_pulses", pulses - base, 1);

      // Hold cleared by an equal-target frame in the middle
      cfgWrite(8'd3);
      stepCycles(1);
      base = pulses;
      for (int f = 1; f <= 5; f++) begin
         applyStimulus(16'd20, 1'b0);
         applyStimulus((f == 3) ? 16'd1000 : 16'd50, 1'b1);
         waitIdle(n);
         checkOutput("holdclr_shift", shift, 3);
      end
      stepCycles(1);
      checkOutput("holdclr_pulses", pulses - base, 0);

      // Manual mode: CFG write applies, auto result never writes
      cfg_auto = 1'b0;
      cfgWrite(8'd5);
      checkOutput("man_shift", shift, 5);
      checkOutput("man_wr_en", wr_en, 1);
      stepCycles(1);
      base = pulses;
      applyStimulus(16'd5, 1'b0);
      applyStimulus(16'd1000, 1'b1);
      checkOutput("man_peak", peak, 1000);
      waitIdle(n);
      checkOutput("man_cycles", n, 4);
      checkOutput("man_shift_kept", shift, 5);
      stepCycles(1);
      checkOutput("man_pulses", pulses - base, 0);

      // Collision: CFG write on the edge of an auto increase to 8
      cfg_auto = 1'b1;
      base = pulses;
      applyStimulus(16'h8000, 1'b1);
      stepCycles(8);
      cfg_shift = 8'd2;
      cfg_wr_en = 1'b1;
      stepCycles(1);
      cfg_wr_en = 1'b0;
      checkOutput("coll_shift", shift, 2);
      checkOutput("coll_wr_en", wr_en, 1);
      checkOutput("coll_busy", busy, 0);
      stepCycles(1);
      checkOutput("coll_pulses", pulses - base, 1);

      // Overrun: short frame closes while a peak-1000 search is running
      cfgWrite(8'd0);
      stepCycles(1);
      checkOutput("ovr_before", overrun, 0);
      base = pulses;
      applyStimulus(16'd5, 1'b0);
      applyStimulus(16'd1000, 1'b1);
      applyStimulus(16'd7, 1'b0);
      applyStimulus(16'd200, 1'b1);
      checkOutput("ovr_flag", overrun, 1);
      checkOutput("ovr_peak", peak, 200);
      checkOutput("ovr_busy", busy, 1);
      waitIdle(n);
      checkOutput("ovr_cycles", n, 2);
      checkOutput("ovr_shift", shift, 3);
      checkOutput("ovr_wr_en", wr_en, 1);
      stepCycles(2);
      checkOutput("ovr_no_restart", busy, 0);
      checkOutput("ovr_pulses", pulses - base, 1);

      // Reset in the middle of a search
      base = pulses;
      applyStimulus(16'h8000, 1'b1);
      stepCycles(3);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_shift", shift, 0);
      checkOutput("midrst_wr_en", wr_en, 0);
      checkOutput("midrst_peak", peak, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_overrun", overrun, 0);
      stepCycles(2);
      rst_n = 1'b1;
      stepCycles(12);
      checkOutput("midrst_shift_after", shift, 0);
      checkOutput("midrst_pulses", pulses - base, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/quant_ctrl.md
# quant_ctrl

Automatic gain controller for the ACO quantizer. Monitors the same 16-bit signed stream the quantizer consumes and measures the per-frame peak magnitude, where a frame ends at `last_i`. From that peak it picks the smallest right-shift that makes the frame fit in signed 8 bits, and writes it to the quantizer's `shift_i`/`wr_en` port. Increases apply immediately; decreases are held off for a configurable number of frames. A manual mode from CFG bypasses the auto result.

## Interface
- `I_BW`, 16: input sample width.
- `SHIFT_BW`, 8: shift register width.
- `MAX_SHIFT`, 8: largest shift the controller will choose; the result is clamped here.
- `HOLD_FRAMES`, 4: consecutive frames that must request a smaller shift before a decrease is applied (1 = immediate).

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `en_i` in 1: sample accept enable; a beat counts only when `en_i & valid_i`.
- `cfg_auto_i` in 1: 1 = auto mode, 0 = manual mode.
- `cfg_shift_i` in SHIFT_BW: manual or seed shift value.
- `cfg_wr_en_i` in 1: one-cycle strobe that writes `cfg_shift_i`.
- `data_i` in I_BW, signed: stream sample.
- `valid_i` in 1: sample valid.
- `last_i` in 1: last beat of frame; qualified by `valid_i & en_i`.
- `shift_o` out SHIFT_BW: current shift; drives the quantizer's `shift_i`.
- `wr_en_o` out 1: one-cycle pulse whenever `shift_o` is written; drives the quantizer's `wr_en`.
- `peak_o` out I_BW-1: peak magnitude of the last completed frame.
- `busy_o` out 1: high while in COMPUTE.
- `overrun_o` out 1: sticky; a frame ended while in COMPUTE.

## Operation
- **Magnitude:** mag = `data_i` if non-negative, else `~data_i` (one's complement). This gives 0..32767 with no overflow at -32768. Rule: `x >>> s` fits in signed 8 bits iff `(mag >> s) <= 127`.
- **Accumulator:** `peak_acc` takes max(`peak_acc`, mag) on every accepted beat in any state.
- **Frame end:** on an accepted beat with `last_i`:
  - `peak_snap` and `peak_o` take max(`peak_acc`, mag).
  - `peak_acc` clears to 0.
- **FSM states:** IDLE and COMPUTE.
- **IDLE:** on an accepted last beat, go to COMPUTE with `cand` = 0.
- **COMPUTE:** one candidate per cycle.
  - If `(peak_snap >> cand) <= 127` or `cand == MAX_SHIFT`, then target = `cand`, run the decision, and go to IDLE.
  - Otherwise increment `cand`.
- **Decision (auto mode only):**
  - target > `shift_o`: write target and clear `hold_cnt`.
  - target < `shift_o`: increment `hold_cnt`. If the new count ≥ HOLD_FRAMES, write target and clear `hold_cnt`.
  - target == `shift_o`: no write; clear `hold_cnt`.
- **Manual mode:** COMPUTE still runs and `peak_o` still updates, but the decision never writes and `hold_cnt` stays 0.
- **CFG write:** `cfg_wr_en_i` in either mode sets `shift_o` = `cfg_shift_i`, pulses `wr_en_o`, and clears `hold_cnt`.
- **Collision:** if a CFG write and an auto write happen on the same edge, CFG wins and the auto result is discarded.
- **Write pulse:** `wr_en_o` is a registered one-cycle pulse on every write, including a write of an unchanged value.
- **Overrun:** an accepted last beat while in COMPUTE does the following:
  - sets `overrun_o`;
  - updates `peak_o` and clears `peak_acc` as normal;
  - leaves `peak_snap` unchanged, so the in-flight compute completes on its own frame's data;
  - drops the new frame from the decision.
- **`en_i` low:** no beats are accepted; an in-flight COMPUTE still completes.

## Timing
- **Reset values:** `shift_o` = 0, `wr_en_o` = 0, `peak_o` = 0, `busy_o` = 0, `overrun_o` = 0. Internally: `peak_acc` = 0, `hold_cnt` = 0, state = IDLE.
- **Reset mid-COMPUTE:** all of the above take effect immediately; no write is issued.
- **Sequence from edge E0** (edge that samples the last beat):
  - At E0: `peak_o` updates, `busy_o` rises, COMPUTE begins.
  - For target k, the decision happens at edge E(k+1). At that edge `shift_o` updates, `wr_en_o` is high for the cycle after E(k+1), and `busy_o` falls.
  - Worst case is MAX_SHIFT+1 cycles.
- **Minimum frame length:** MAX_SHIFT+2 beats avoids overrun.
- **CFG write latency:** `shift_o` and `wr_en_o` update at the edge that samples `cfg_wr_en_i`.
- **No handshake:** there is no back-pressure; the controller observes the stream only.

## Test plan
- Reset, then a frame with peak +100, last beat at E0 → `peak_o` = 100, target 0, decision at E1, no `wr_en_o`, `shift_o` stays 0.
- Frame with peak +1000 → `busy_o` for 4 cycles, `shift_o` = 3 at E4, single `wr_en_o` pulse.
- Frame containing -32768 → `peak_o` = 32767, `shift_o` = 8 at E9.
- Starting from `shift_o` = 3, four frames with peak 50, HOLD_FRAMES = 4 → no write after frames 1–3; `shift_o` = 0 with a pulse after frame 4.
  - Repeat, with a peak-1000 frame inserted after frame 2 → `hold_cnt` clears, `shift_o` stays 3.
- Manual mode: `cfg_wr_en_i` with `cfg_shift_i` = 5 → `shift_o` = 5 and a pulse.
  - Then a frame with peak 1000 → `peak_o` = 1000, no write.
  - CFG write on the same edge as an auto decision → CFG value wins.
- Two-beat frame ending while a peak-1000 compute is busy → `overrun_o` = 1, first decision still `shift_o` = 3.
  - Assert `rst_n_i` low mid-COMPUTE → all outputs 0 and no `wr_en_o`.
